screen_sequencer: RTL and testbench
===================================

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 Parameter FADE_FRAMES, default 4: frames per fade step.
REQ-002 Parameter HOLD_FRAMES, default 180: frames the game-over screen holds at full brightness.
REQ-003 Parameter LIVES, default 3: lives loaded on entering PLAY; legal range 1..7.
REQ-004 vga_clk  in  1  pixel clock; the only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 DrawX, DrawY  in  10 each  current pixel coordinates.
REQ-007 blank  in  1  1 = active video, 0 = blanking.
REQ-008 start_key  in  1  level input from the start key; synchronous to vga_clk.
REQ-009 player_dead  in  1  one-cycle pulse per player death.
REQ-010 title_rgb, game_rgb, over_rgb  in  12 each  {r,g,b} 4 bits per channel from the three screen mappers.
REQ-011 red, green, blue  out  4 each  registered pixel output.
REQ-012 state  out  3  current state encoding.
REQ-013 lives  out  3  remaining lives.
REQ-014 fade_level  out  4  current brightness, 0..8.

Function
REQ-015 Frame tick:
- frame_tick SHALL be a one-cycle internal pulse in the cycle where DrawX==0 and DrawY==0.
- All frame counters SHALL advance only on frame_tick.
REQ-016 Start-key edge detection:
- start_key SHALL be registered once.
- start_edge SHALL be the condition start_key==1 and the registered copy==0.
REQ-017 State encoding: TITLE=0, PLAY=1, GO_FADE_IN=2, GO_HOLD=3, GO_FADE_OUT=4.
REQ-018 TITLE -> PLAY on start_edge; on that transition lives SHALL load LIVES.
REQ-019 In PLAY, player_dead with lives>1 SHALL decrement lives and stay in PLAY.
REQ-020 In PLAY, player_dead with lives==1 SHALL set lives=0, fade_level=0 and frame counter=0, and go to GO_FADE_IN.
REQ-021 In PLAY, when player_dead and start_edge occur in the same cycle, player_dead SHALL win and start_edge SHALL be ignored.
REQ-022 GO_FADE_IN behaviour:
- Every FADE_FRAMES frame_ticks, fade_level SHALL increment by 1.
- In the cycle fade_level becomes 8, the state SHALL move to GO_HOLD with frame counter=0.
REQ-023 GO_HOLD behaviour:
- After HOLD_FRAMES frame_ticks, the state SHALL move to GO_FADE_OUT.
- A start_edge in GO_HOLD SHALL move to GO_FADE_OUT on the next cycle.
- On either transition the frame counter SHALL be 0.
REQ-024 GO_FADE_OUT behaviour:
- Every FADE_FRAMES frame_ticks, fade_level SHALL decrement by 1.
- In the cycle fade_level becomes 0, the state SHALL move to TITLE.
REQ-025 fade_level SHALL saturate at 0 and 8, never wrap, and hold its value in TITLE and PLAY.
REQ-026 start_edge and player_dead SHALL be ignored in GO_FADE_IN and GO_FADE_OUT.
REQ-027 player_dead SHALL be ignored in TITLE and GO_HOLD.
REQ-028 Source select:
- TITLE selects title_rgb.
- PLAY selects game_rgb.
- GO_* states select over_rgb.
REQ-029 In GO_* states each output channel SHALL be (channel * fade_level) >> 3, computed at least 8 bits wide then truncated to 4 bits; fade_level=8 SHALL pass the channel unchanged.
REQ-030 In TITLE and PLAY, channels SHALL pass unscaled.
REQ-031 red/green/blue SHALL be registered: one vga_clk of latency from the input rgb to the output.
REQ-032 red/green/blue SHALL be 0 in any cycle following blank==0.
REQ-033 The frame counter SHALL be wide enough for max(FADE_FRAMES, HOLD_FRAMES), i.e. at least 8 bits at the defaults.

Reset
REQ-034 On reset the block SHALL set:
- state=TITLE, lives=0, fade_level=0, frame counter=0
- start_key register=1, so a key already held at reset does not produce an edge
- red=green=blue=0
REQ-035 Reset SHALL override all other inputs in the same cycle; reset mid-fade SHALL return to TITLE with no residual fade.

Verification
REQ-036 Reset, then a start_key 0->1 -> state=1 and lives=3 on the next cycle; holding the key produces no further transition.
REQ-037 In PLAY, three player_dead pulses -> lives 2, 1, then state=2 with lives=0 and fade_level=0.
REQ-038 Run GO_FADE_IN with FADE_FRAMES=4 and over_rgb=12'hFFF:
- fade_level SHALL step 1..8 every 4 frames.
- At level 4 the output SHALL be 12'h777.
- At level 8 the output SHALL be 12'hFFF and state=3.
REQ-039 In GO_HOLD:
- With no key, state=4 after 180 frames.
- Repeat with start_edge at frame 10: state=4 next cycle, then 32 frames of fade-out to state=0.
REQ-040 Simultaneous events:
- player_dead and start_edge in the same cycle with lives=1 -> state=2.
- blank=0 in PLAY -> rgb=0 one cycle later.
REQ-041 Reset asserted in GO_FADE_OUT at fade_level=5 -> next cycle state=0, fade_level=0, rgb=0.

Source files
------------

// File: rtl/screen_sequencer.sv
// screen_sequencer: title/play/game-over screen FSM with frame-timed fade
// and a registered, brightness-scaled pixel mux.
module screen_sequencer #(
   parameter int FADE_FRAMES = 4,
   parameter int HOLD_FRAMES = 180,
   parameter int LIVES       = 3
) (
   input  logic        vga_clk,
   input  logic        reset,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        blank,
   input  logic        start_key,
   input  logic        player_dead,
   input  logic [11:0] title_rgb,
   input  logic [11:0] game_rgb,
   input  logic [11:0] over_rgb,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic [2:0]  state,
   output logic [2:0]  lives,
   output logic [3:0]  fade_level
);
   localparam int MAX_FRAMES = (FADE_FRAMES > HOLD_FRAMES) ? FADE_FRAMES : HOLD_FRAMES;
   localparam int CW = ($clog2(MAX_FRAMES + 1) > 8) ? $clog2(MAX_FRAMES + 1) : 8;
   localparam logic [CW-1:0] FADE_LAST = CW'(FADE_FRAMES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);

   typedef enum logic [2:0] {
      TITLE       = 3'd0,
      PLAY        = 3'd1,
      GO_FADE_IN  = 3'd2,
      GO_HOLD     = 3'd3,
      GO_FADE_OUT = 3'd4
   } state_t;

   state_t        r_state, w_state_nx;
   logic [2:0]    r_lives, w_lives_nx;
   logic [3:0]    r_fade, w_fade_nx;
   logic [CW-1:0] r_cnt, w_cnt_nx;
   logic          r_key_q;
   logic [11:0]   r_rgb;
   logic          w_tick, w_start_edge, w_over;
   logic [11:0]   w_src, w_pix;
   logic [3:0]    w_scale;

   assign w_tick       = (DrawX == 10'd0) && (DrawY == 10'd0);
   assign w_start_edge = start_key & ~r_key_q;

   // Key register resets high so a key held through reset is not an edge.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_state <= TITLE;
         r_lives <= 3'd0;
         r_fade  <= 4'd0;
         r_cnt   <= '0;
         r_key_q <= 1'b1;
         r_rgb   <= 12'd0;
      end else begin
         r_state <= w_state_nx;
         r_lives <= w_lives_nx;
         r_fade  <= w_fade_nx;
         r_cnt   <= w_cnt_nx;
         r_key_q <= start_key;
         r_rgb   <= blank ? w_pix : 12'd0;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_lives_nx = r_lives;
      w_fade_nx  = r_fade;
      w_cnt_nx   = r_cnt;
      case (r_state)
         TITLE: begin
            if (w_start_edge) begin
               w_state_nx = PLAY;
               w_lives_nx = 3'(LIVES);
            end
         end
         PLAY: begin
            if (player_dead) begin
               if (r_lives > 3'd1) begin
                  w_lives_nx = r_lives - 3'd1;
               end else begin
                  w_lives_nx = 3'd0;
                  w_fade_nx  = 4'd0;
                  w_cnt_nx   = '0;
                  w_state_nx = GO_FADE_IN;
               end
            end
         end
         GO_FADE_IN: begin
            if (w_tick) begin
               if (r_cnt == FADE_LAST) begin
                  w_cnt_nx  = '0;
                  w_fade_nx = (r_fade < 4'd8) ? r_fade + 4'd1 : r_fade;
                  if (r_fade >= 4'd7) w_state_nx = GO_HOLD;
               end else begin
                  w_cnt_nx = r_cnt + CW'(1);
               end
            end
         end
         GO_HOLD: begin
            if (w_start_edge) begin
               w_cnt_nx   = '0;
               w_state_nx = GO_FADE_OUT;
            end else if (w_tick) begin
               if (r_cnt == HOLD_LAST) begin
                  w_cnt_nx   = '0;
                  w_state_nx = GO_FADE_OUT;
               end else begin
                  w_cnt_nx = r_cnt + CW'(1);
               end
            end
         end
         GO_FADE_OUT: begin
            if (w_tick) begin
               if (r_cnt == FADE_LAST) begin
                  w_cnt_nx  = '0;
                  w_fade_nx = (r_fade > 4'd0) ? r_fade - 4'd1 : r_fade;
                  if (r_fade <= 4'd1) w_state_nx = TITLE;
               end else begin
                  w_cnt_nx = r_cnt + CW'(1);
               end
            end
         end
         default: w_state_nx = TITLE;
      endcase
   end

   // Full brightness is 8, so scale 8 with >>3 passes a channel unchanged.
   assign w_over  = (r_state != TITLE) && (r_state != PLAY);
   assign w_src   = (r_state == TITLE) ? title_rgb : (r_state == PLAY) ? game_rgb : over_rgb;
   assign w_scale = w_over ? r_fade : 4'd8;
   assign w_pix[11:8] = 4'(({4'd0, w_src[11:8]} * {4'd0, w_scale}) >> 3);
   assign w_pix[7:4]  = 4'(({4'd0, w_src[7:4]}  * {4'd0, w_scale}) >> 3);
   assign w_pix[3:0]  = 4'(({4'd0, w_src[3:0]}  * {4'd0, w_scale}) >> 3);

   assign red        = r_rgb[11:8];
   assign green      = r_rgb[7:4];
   assign blue       = r_rgb[3:0];
   assign state      = r_state;
   assign lives      = r_lives;
   assign fade_level = r_fade;
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: random pixel/event stimulus against a frame-counting
// reference model of the screen sequencer.
module tb_screen_sequencer;
   localparam int F = 4;
   localparam int H = 180;
   localparam int L = 3;

   logic        vga_clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  DrawX = 10'd1, DrawY = 10'd1;
   logic        blank = 1'b1, start_key = 1'b1, player_dead = 1'b0;
   logic [11:0] title_rgb = 12'd0, game_rgb = 12'd0, over_rgb = 12'd0;
   logic [3:0]  red, green, blue, fade_level;
   logic [2:0]  state, lives;

   screen_sequencer #(.FADE_FRAMES(F), .HOLD_FRAMES(H), .LIVES(L)) dut (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .start_key(start_key), .player_dead(player_dead),
      .title_rgb(title_rgb), .game_rgb(game_rgb), .over_rgb(over_rgb),
      .red(red), .green(green), .blue(blue),
      .state(state), .lives(lives), .fade_level(fade_level)
   );

   always #5 vga_clk = ~vga_clk;

   int checks = 0, errors = 0, cyc_n = 0;
   bit key_v = 1'b1, fix_over = 1'b0;
   int blank_mode = 0;
   // Model: phase + frames elapsed in phase; brightness derived from elapsed frames.
   int m_st = 0, m_lives = 0, m_fade = 0, m_ticks = 0, m_rgb = 0;
   bit m_prevkey = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
      end
   endtask

   function automatic int shade(input int rgb, input int lvl);
      return ((((rgb >> 8) & 15) * lvl / 8) << 8) | ((((rgb >> 4) & 15) * lvl / 8) << 4)
             | ((rgb & 15) * lvl / 8);
   endfunction

   task automatic model_step(input bit tick, input bit bl, input bit key, input bit d, input bit r);
      bit edge_k;
      int src;
      edge_k = key && !m_prevkey;
      m_prevkey = key;
      if (r) begin
         m_st = 0; m_lives = 0; m_fade = 0; m_ticks = 0; m_rgb = 0; m_prevkey = 1'b1;
         return;
      end
      src = (m_st == 0) ? int'(title_rgb) : (m_st == 1) ? int'(game_rgb) : int'(over_rgb);
      m_rgb = bl ? shade(src, (m_st >= 2) ? m_fade : 8) : 0;
      case (m_st)
         0: if (edge_k) begin m_st = 1; m_lives = L; end
         1: if (d) begin
               if (m_lives > 1) m_lives--;
               else begin m_lives = 0; m_fade = 0; m_ticks = 0; m_st = 2; end
            end
         2: if (tick) begin
               m_ticks++;
               m_fade = m_ticks / F;
               if (m_fade == 8) begin m_st = 3; m_ticks = 0; end
            end
         3: if (edge_k) begin m_st = 4; m_ticks = 0; end
            else if (tick) begin
               m_ticks++;
               if (m_ticks == H) begin m_st = 4; m_ticks = 0; end
            end
         default: if (tick) begin
               m_ticks++;
               m_fade = 8 - m_ticks / F;
               if (m_fade == 0) begin m_st = 0; m_ticks = 0; end
            end
      endcase
   endtask

   task automatic cyc(input bit d, input bit r);
      bit tick;
      tick = (cyc_n % 4 == 0);
      if (tick) begin
         DrawX = 10'd0; DrawY = 10'd0;
      end else begin
         DrawX = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 799));
         DrawY = 10'($urandom_range(1, 524));
      end
      title_rgb = 12'($urandom);
      game_rgb  = 12'($urandom);
      over_rgb  = fix_over ? 12'hFFF : 12'($urandom);
      blank = (blank_mode == 0) ? 1'b1 : (blank_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      start_key = key_v; player_dead = d; reset = r;
      model_step(tick, blank, key_v, d, r);
      @(posedge vga_clk);
      #1;
      check("state", state, m_st);
      check("lives", lives, m_lives);
      check("fade", fade_level, m_fade);
      check("rgb", {red, green, blue}, m_rgb);
      cyc_n++;
   endtask

   task automatic run_until(input int target, input int limit);
      int n = 0;
      while (m_st != target && n < limit) begin
         key_v = (m_st == 2 || m_st == 4) ? bit'($urandom_range(0, 1)) : 1'b0;
         cyc($urandom_range(0, 15) == 0, 1'b0);
         n++;
      end
      key_v = 1'b0;
      check("reach_state", state, target);
   endtask

   task automatic run_fade(input int lvl, input int limit);
      int n = 0;
      while (m_fade != lvl && n < limit) begin
         cyc($urandom_range(0, 15) == 0, 1'b0);
         n++;
      end
      check("reach_fade", fade_level, lvl);
   endtask

   task automatic start_game();
      key_v = 1'b0; cyc(0, 0);
      key_v = 1'b1; cyc(0, 0);
      check("start_state", state, 1);
      check("start_lives", lives, L);
   endtask

   task automatic lose_all();
      for (int i = 0; i < L; i++) begin
         repeat ($urandom_range(2, 8)) cyc(0, 0);
         cyc(1, 0);
      end
      key_v = 1'b0;
      check("game_over", state, 2);
   endtask

   initial begin
      cyc(0, 1); cyc(0, 1);
      repeat (3) cyc(0, 0);
      check("held_key_no_start", state, 0);
      start_game();
      repeat (5) cyc(0, 0);
      check("held_key_no_retrigger", state, 1);
      blank_mode = 1;
      repeat (20) cyc(0, 0);
      cyc(1, 0);
      check("lives_after_1", lives, 2);
      repeat ($urandom_range(3, 10)) cyc(0, 0);
      cyc(1, 0);
      check("lives_after_2", lives, 1);
      blank_mode = 2;
      cyc(0, 0);
      check("blank_rgb", {red, green, blue}, 12'd0);
      blank_mode = 0;
      key_v = 1'b0; cyc(0, 0);
      key_v = 1'b1; cyc(1, 0);
      check("dead_beats_start", state, 2);
      check("dead_lives0", lives, 0);
      check("dead_fade0", fade_level, 0);
      key_v = 1'b0;
      fix_over = 1'b1;
      run_fade(4, 200);
      cyc(0, 0);
      check("fade4_rgb", {red, green, blue}, 12'h777);
      run_until(3, 200);
      cyc(0, 0);
      check("fade8_rgb", {red, green, blue}, 12'hFFF);
      fix_over = 1'b0; blank_mode = 1;
      run_until(4, 1000);
      run_until(0, 400);
      start_game();
      lose_all();
      run_until(3, 300);
      repeat (40) cyc($urandom_range(0, 1) == 1, 1'b0);
      check("hold_still", state, 3);
      key_v = 1'b1; cyc(0, 0);
      check("hold_key_exit", state, 4);
      key_v = 1'b0;
      run_until(0, 400);
      start_game();
      lose_all();
      run_until(3, 300);
      key_v = 1'b1; cyc(0, 0); key_v = 1'b0;
      run_fade(5, 200);
      check("pre_rst_state", state, 4);
      cyc(0, 1);
      check("rst_state", state, 0);
      check("rst_fade", fade_level, 0);
      check("rst_rgb", {red, green, blue}, 12'd0);
      repeat (5) cyc(0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
